seg_pattern_rx: RTL and testbench
=================================

Name: seg_pattern_rx

Overview:
- Receiving end of the ALU display interface: samples the 7-bit active-low segment bus driven by the ALU display decoder and recovers the 3-bit digit and the overflow indication.
- Qualifies each pattern by requiring it to be stable for a set number of cycles, then reports it over a valid/ready handshake.
- Used by self-checking lab benches and by the board loopback monitor that reads the display pins.

Parameters:
- STABLE_CYCLES, 4, consecutive clock edges a pattern must be sampled unchanged before it is accepted. Legal range 2..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  segment bus, active-low; bit0=a … bit6=g.
- ready  input  1  consumer accepts the current report.
- s_out  output  3  decoded digit 0..7.
- ovfl_out  output  1  1 = overflow ("E") pattern received.
- valid  output  1  report pending; held until accepted.
- err  output  1  one-cycle pulse: stable pattern is not a legal code.
- drop  output  1  one-cycle pulse: stable pattern discarded because the previous report is not yet accepted.

Behaviour:
- Reset:
  - Asynchronous, active-low; one clock; all state on clk rising edge.
  - Reset values: s_out=0, ovfl_out=0, valid=0, err=0, drop=0.
  - The internal last-pattern register resets to blank (7'b1111111), with the stability counter saturated. A blank bus after reset therefore produces no report.
- Legal codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000.
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - E=0000110 decodes to s=0, ovfl=1.
  - Blank=1111111 is recognised and never reported.
  - Any other pattern is illegal.
- Stability qualification:
  - At each edge, if seg differs from the last-pattern register, load it and clear the counter.
  - Otherwise the counter increments, saturating.
  - A pattern is accepted exactly once: at the STABLE_CYCLES-th consecutive edge on which it is sampled. Outputs are visible after that edge.
  - The pattern then stays locked, with no repeat reports, until seg changes.
- FSM states:
  - IDLE: no report pending.
  - HOLD: valid=1, waiting for ready.
- Acceptance event in IDLE:
  - Legal digit or E: load s_out/ovfl_out, set valid, go to HOLD.
  - Illegal pattern: pulse err for one cycle, stay in IDLE.
  - Blank: no action.
- HOLD:
  - s_out, ovfl_out and valid are held constant.
  - On an edge with ready=1: valid goes to 0, return to IDLE.
  - ready while IDLE is ignored.
- Acceptance event while in HOLD (legal or illegal, not blank):
  - The pattern is discarded and drop pulses for one cycle. err is not raised for it.
  - The HOLD report is unchanged.
  - If ready=1 on the same edge, the handshake completes and the new pattern is still dropped. No event is queued.
- Glitches: a pattern held fewer than STABLE_CYCLES edges is ignored entirely.
- Mid-operation reset: asserting rst_n low at any time clears valid and the pulses immediately, and abandons the pending report.
- s_out/ovfl_out retain their last reported value in IDLE.
- err and drop are never high for more than one consecutive cycle per event.

Test Plan:
1. Reset with seg=1111111, then hold 20 cycles -> valid, err and drop stay 0; s_out=0, ovfl_out=0.
2. seg=0100100 held 6 cycles, ready=0 -> valid rises after the 4th sampling edge with s_out=2, ovfl_out=0. Assert ready one cycle -> valid=0 next edge. No second report while seg stays 0100100.
3. seg=0000110 held 4 cycles, ready=1 -> valid high for exactly one cycle with s_out=0, ovfl_out=1.
4. seg=1111001 held for 3 cycles, then 1111000 held for 4 cycles -> no report for 1; a single report with s_out=7.
5. seg=0110000 accepted with ready=0, then seg=0011001 held 4 cycles -> drop pulses once, valid stays high with s_out=3. Then seg=0101010 held 4 cycles -> drop pulses again, err stays 0. After ready, seg=0101010 re-presented from blank -> err pulse, valid stays 0.
6. Report pending (valid=1, s_out=5), pull rst_n low mid-cycle -> valid=0 immediately. After release with seg=0010010 still stable, it is re-reported after 4 edges.

Source files
------------

// File: rtl/seg_pattern_rx_if.sv
// Purpose: groups the segment bus and the report handshake of seg_pattern_rx.
// Signals:
//   seg      - 7-bit active-low segment bus (bit0=a .. bit6=g).
//   ready    - consumer accepts the current report.
//   s_out    - decoded digit 0..7.
//   ovfl_out - overflow ("E") pattern received.
//   valid    - report pending, held until accepted.
//   err      - one-cycle pulse, stable pattern is not a legal code.
//   drop     - one-cycle pulse, stable pattern discarded while a report is pending.
// Modports:
//   master - the side driving seg and ready (display source plus consumer).
//   slave  - the receiver itself.
interface seg_pattern_rx_if;
  logic [6:0] seg;
  logic       ready;
  logic [2:0] s_out;
  logic       ovfl_out;
  logic       valid;
  logic       err;
  logic       drop;

  modport master (
    output seg, ready,
    input  s_out, ovfl_out, valid, err, drop
  );

  modport slave (
    input  seg, ready,
    output s_out, ovfl_out, valid, err, drop
  );
endinterface

// File: rtl/seg_pattern_rx.sv
// Purpose: receiving end of the ALU display interface. Samples the active-low
// segment bus, qualifies a pattern once it has been sampled unchanged on
// STABLE_CYCLES consecutive edges, decodes it to a 3-bit digit plus an
// overflow flag and reports it over a valid/ready handshake.
// Ports:
//   clk   - system clock, rising edge.
//   rst_n - asynchronous active-low reset.
//   bus   - seg_pattern_rx_if.slave: seg/ready in; s_out/ovfl_out/valid/err/drop out.
// Parameters:
//   STABLE_CYCLES - edges a pattern must be seen unchanged before acceptance (2..15).
module seg_pattern_rx #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_pattern_rx_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  localparam logic [6:0] PAT_BLANK = 7'b1111111;

  // The counter holds (edges seen) - 1 for the current pattern, so it tops
  // out at STABLE_CYCLES-1 and the acceptance edge is the one that moves it
  // from STABLE_CYCLES-2 to the top value.
  localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CNT_FIRE = 4'(STABLE_CYCLES - 2);

  logic [6:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [0:0] state_q, state_d;
  logic [2:0] s_q, s_d;
  logic       ovfl_q, ovfl_d;
  logic       err_q, err_d;
  logic       drop_q, drop_d;

  logic       stable;
  logic       accept;
  logic       code_legal;
  logic       code_blank;
  logic       code_ovfl;
  logic [2:0] code_digit;

  // Decode of the live bus; only consulted on the acceptance edge, when
  // seg equals the locked pattern.
  always_comb begin
    code_legal = 1'b1;
    code_blank = 1'b0;
    code_ovfl  = 1'b0;
    code_digit = 3'd0;
    case (bus.seg)
      7'b1000000: code_digit = 3'd0;
      7'b1111001: code_digit = 3'd1;
      7'b0100100: code_digit = 3'd2;
      7'b0110000: code_digit = 3'd3;
      7'b0011001: code_digit = 3'd4;
      7'b0010010: code_digit = 3'd5;
      7'b0000010: code_digit = 3'd6;
      7'b1111000: code_digit = 3'd7;
      7'b0000110: code_ovfl  = 1'b1;
      PAT_BLANK: begin
        code_legal = 1'b0;
        code_blank = 1'b1;
      end
      default:    code_legal = 1'b0;
    endcase
  end

  assign stable = (bus.seg == last_q);
  assign accept = stable && (cnt_q == CNT_FIRE);

  always_comb begin
    last_d  = bus.seg;
    cnt_d   = '0;
    state_d = state_q;
    s_d     = s_q;
    ovfl_d  = ovfl_q;
    err_d   = 1'b0;
    drop_d  = 1'b0;

    if (stable) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (accept && code_legal) begin
          s_d     = code_digit;
          ovfl_d  = code_ovfl;
          state_d = HOLD;
        end else if (accept && !code_blank) begin
          err_d = 1'b1;
        end
      end
      HOLD: begin
        // A new pattern arriving while a report waits is never queued,
        // even when the handshake completes on the same edge.
        if (accept && !code_blank) begin
          drop_d = 1'b1;
        end
        if (bus.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset leaves the last pattern blank with the counter saturated, so a
  // blank bus coming out of reset can never fire an acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= PAT_BLANK;
      cnt_q   <= CNT_MAX;
      state_q <= IDLE;
      s_q     <= 3'd0;
      ovfl_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      s_q     <= s_d;
      ovfl_q  <= ovfl_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.s_out    = s_q;
  assign bus.ovfl_out = ovfl_q;
  assign bus.valid    = (state_q == HOLD);
  assign bus.err      = err_q;
  assign bus.drop     = drop_q;

endmodule

// File: tb/tb_seg_pattern_rx.sv
// Purpose: self-checking bench for seg_pattern_rx. Directed sequences from the
// display use cases followed by randomized pattern streams with random ready
// and occasional mid-cycle resets, all compared every cycle against a
// behavioural model built from a sample history window and a pending-report flag.
module tb_seg_pattern_rx;

  localparam int N = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] PAT_E = 7'b0000110;

  logic clk = 1'b0;
  logic rst_n;

  seg_pattern_rx_if bus();

  seg_pattern_rx #(.STABLE_CYCLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [6:0] digit_pat [8];

  // Reference model state.
  logic [6:0] hist [$];
  logic       exp_pend;
  logic [2:0] exp_s;
  logic       exp_ovfl;
  logic       exp_err;
  logic       exp_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= N; i++) hist.push_back(BLANK);
    exp_pend = 1'b0;
    exp_s    = 3'd0;
    exp_ovfl = 1'b0;
    exp_err  = 1'b0;
    exp_drop = 1'b0;
  endtask

  // One rising edge with inputs s/r: a pattern is accepted when the newest N
  // samples all equal it and the sample just before them does not.
  task automatic model_edge(input logic [6:0] s, input logic r);
    bit ev;
    int idx;
    hist.push_back(s);
    void'(hist.pop_front());
    ev = (hist[0] != s);
    for (int k = 1; k <= N; k++) if (hist[k] != s) ev = 0;
    idx = -1;
    for (int d = 0; d < 8; d++) if (digit_pat[d] == s) idx = d;
    exp_err  = 1'b0;
    exp_drop = 1'b0;
    if (exp_pend) begin
      if (ev && s != BLANK) exp_drop = 1'b1;
      if (r) exp_pend = 1'b0;
    end else if (ev) begin
      if (idx >= 0) begin
        exp_pend = 1'b1;
        exp_s    = 3'(idx);
        exp_ovfl = 1'b0;
      end else if (s == PAT_E) begin
        exp_pend = 1'b1;
        exp_s    = 3'd0;
        exp_ovfl = 1'b1;
      end else if (s != BLANK) begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string where);
    check({where, ".valid"}, 32'(bus.valid), 32'(exp_pend));
    check({where, ".err"},   32'(bus.err),   32'(exp_err));
    check({where, ".drop"},  32'(bus.drop),  32'(exp_drop));
    check({where, ".data"},  32'({bus.ovfl_out, bus.s_out}), 32'({exp_ovfl, exp_s}));
  endtask

  task automatic cycle(input logic [6:0] s, input logic r);
    bus.seg   = s;
    bus.ready = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    if (bus.valid || bus.err || bus.drop || exp_pend || exp_err || exp_drop)
      $display("t=%0t seg=%b rdy=%b valid=%b s=%0d ovfl=%b err=%b drop=%b",
               $time, s, r, bus.valid, bus.s_out, bus.ovfl_out, bus.err, bus.drop);
    compare_all("cyc");
  endtask

  task automatic hold(input logic [6:0] s, input int n, input logic r);
    for (int i = 0; i < n; i++) cycle(s, r);
  endtask

  // Called just after an edge: assert reset mid-cycle, check outputs cleared
  // before any clock edge, release before the next edge.
  task automatic mid_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    $display("t=%0t mid-cycle reset", $time);
    compare_all("rst");
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] pat;
    int len;
    int sel;
    digit_pat[0] = 7'b1000000; digit_pat[1] = 7'b1111001;
    digit_pat[2] = 7'b0100100; digit_pat[3] = 7'b0110000;
    digit_pat[4] = 7'b0011001; digit_pat[5] = 7'b0010010;
    digit_pat[6] = 7'b0000010; digit_pat[7] = 7'b1111000;

    rst_n     = 1'b0;
    bus.seg   = BLANK;
    bus.ready = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    #5 rst_n = 1'b1;

    // Blank after reset never reports.
    hold(BLANK, 20, 1'b0);
    // Digit 2 with a late ready, then no repeat while it stays.
    hold(7'b0100100, 6, 1'b0);
    check("t2.s_out", 32'(bus.s_out), 32'd2);
    cycle(7'b0100100, 1'b1);
    hold(7'b0100100, 4, 1'b0);
    // Overflow pattern with ready held high.
    hold(BLANK, 2, 1'b0);
    hold(PAT_E, 4, 1'b1);
    check("t3.ovfl", 32'(bus.ovfl_out), 32'd1);
    hold(BLANK, 2, 1'b1);
    // Short glitch of 1 followed by a stable 7.
    hold(7'b1111001, 3, 1'b0);
    hold(7'b1111000, 4, 1'b0);
    check("t4.s_out", 32'(bus.s_out), 32'd7);
    cycle(7'b1111000, 1'b1);
    // Drops while a report is pending, then an illegal code raises err.
    hold(7'b0110000, 4, 1'b0);
    hold(7'b0011001, 4, 1'b0);
    hold(7'b0101010, 4, 1'b0);
    check("t5.s_out", 32'(bus.s_out), 32'd3);
    cycle(7'b0101010, 1'b1);
    hold(BLANK, 2, 1'b0);
    hold(7'b0101010, 4, 1'b0);
    // Reset abandons a pending report; the stable pattern is re-reported.
    hold(7'b0010010, 4, 1'b0);
    check("t6.s_out", 32'(bus.s_out), 32'd5);
    mid_reset();
    hold(7'b0010010, 5, 1'b0);
    cycle(7'b0010010, 1'b1);

    // Randomized pattern streams.
    for (int seg_i = 0; seg_i < 300; seg_i++) begin
      sel = int'($urandom_range(0, 11));
      if (sel < 8)       pat = digit_pat[sel];
      else if (sel == 8) pat = PAT_E;
      else if (sel == 9) pat = BLANK;
      else               pat = 7'($urandom);
      len = int'($urandom_range(1, 2 * N));
      for (int c = 0; c < len; c++) cycle(pat, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 39) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
